permutator_slice_pipe: RTL and testbench

- Parametrised, registered successor to the single-slice permutator.
- Implements an N-stage butterfly select chain over DW-bit data. Each stage picks between its own tap and the previous stage's result, steered by a backward-propagating address chain XORed with a per-stage config bit.
- Results and forwarded tap addresses are captured into a 2-entry output skid buffer behind valid/ready handshakes.
- Config is held in a writable shadow register.
- Sits between the lane-tap stage and the downstream piston datapath.

---
 rtl/permutator_pkg.sv | 30 +++
 rtl/permutator_slice_pipe_skid2.sv | 63 ++++++
 rtl/permutator_slice_pipe.sv | 121 ++++++++++++
 tb/tb_permutator_slice_pipe.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/permutator_pkg.sv
// permutator_pkg: shared defaults, packed-slice offsets and beat layout
// for the registered permutator slice pipeline.
package permutator_pkg;

    localparam int DW_DEFAULT     = 32;
    localparam int STAGES_DEFAULT = 4;

    typedef struct packed {
        logic [(STAGES_DEFAULT+1)*DW_DEFAULT-1:0]   i_dat;
        logic [STAGES_DEFAULT*STAGES_DEFAULT-1:0]   t_adr;
    } perm_beat_t;

    function automatic int dat_off(input int k, input int dw);
        return k * dw;
    endfunction

    function automatic int adr_off(input int k, input int s);
        return (k - 1) * s;
    endfunction

    function automatic logic [63:0] low_mask(input int n);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/permutator_slice_pipe_skid2.sv
// permutator_skid2: generic 2-entry in-order valid/ready skid buffer.
// in_ready depends only on the fill count and rst, never on out_ready.
module permutator_skid2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [1:0]   cnt;
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         push;
    logic         pop;

    assign in_ready  = (cnt != 2'd2) && !rst;
    assign out_valid = (cnt != 2'd0);
    assign out_data  = head;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // head is the output register; tail only fills while head is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            case (cnt)
                2'd0: begin
                    if (push) begin
                        head <= in_data;
                        cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= in_data;
                    end else if (push) begin
                        tail <= in_data;
                        cnt  <= 2'd2;
                    end else if (pop) begin
                        cnt <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head <= tail;
                        cnt  <= 2'd1;
                    end
                end
                default: cnt <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/permutator_slice_pipe.sv
// permutator_slice_pipe: registered N-stage butterfly select chain.
// Optional conflict detection under PERMUTATOR_SLICE_PIPE_CONFLICT_EN.
module permutator_slice_pipe
    import permutator_pkg::*;
#(
    parameter int                DW      = DW_DEFAULT,
    parameter int                STAGES  = STAGES_DEFAULT,
    parameter logic [STAGES-1:0] CFG_RST = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [(STAGES+1)*DW-1:0]   t_dat,
    input  logic [STAGES*STAGES-1:0]   i_adr,
    input  logic                       cfg_wr,
    input  logic [STAGES-1:0]          cfg_wdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [(STAGES+1)*DW-1:0]   i_dat,
    output logic [STAGES*STAGES-1:0]   t_adr,
    output logic [STAGES-1:0]          cfg_q
`ifdef PERMUTATOR_SLICE_PIPE_CONFLICT_EN
    ,
    input  logic                       err_clr,
    output logic                       err
`endif
);

    localparam int S = STAGES;

    typedef struct packed {
        logic [(S+1)*DW-1:0] i_dat;
        logic [S*S-1:0]      t_adr;
    } beat_t;

    logic [S-1:0]  ia   [1:S];
    logic [S-1:0]  adr  [1:S];
    logic [S-1:0]  rest [1:S];
    logic [S-1:0]  back [1:S+1];
    logic [S-1:0]  fwd  [1:S];
    logic [S:1]    sel;
    logic [DW-1:0] dat  [0:S];
    beat_t         beat_d;
    beat_t         beat_q;

    assign back[S+1] = '0;
    assign dat[0]    = t_dat[dat_off(0, DW) +: DW];

    // address flows from stage S downwards, data from stage 0 upwards
    for (genvar k = 1; k <= S; k++) begin : g_stage
        localparam logic [63:0] MK = low_mask(k);
        localparam logic [63:0] MR = low_mask(k - 1);

        assign ia[k]   = i_adr[adr_off(k, S) +: S] & MK[S-1:0];
        assign adr[k]  = ia[k] | back[k+1];
        assign sel[k]  = adr[k][0] ^ cfg_q[S-k];
        assign rest[k] = (adr[k] >> 1) & MR[S-1:0];
        assign back[k] = sel[k] ? '0 : rest[k];
        assign fwd[k]  = sel[k] ? rest[k] : '0;
        assign dat[k]  = sel[k] ? t_dat[dat_off(k, DW) +: DW]
                                : dat[k-1];
    end

    always_comb begin
        beat_d = '0;
        for (int k = 0; k <= S; k++) begin
            beat_d.i_dat[k*DW +: DW] = dat[k];
        end
        for (int k = 1; k <= S; k++) begin
            beat_d.t_adr[(k-1)*S +: S] = fwd[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q <= CFG_RST;
        end else if (cfg_wr) begin
            cfg_q <= cfg_wdata;
        end
    end

    permutator_skid2 #(
        .W($bits(beat_t))
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (beat_d),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (beat_q)
    );

    assign i_dat = beat_q.i_dat;
    assign t_adr = beat_q.t_adr;

`ifdef PERMUTATOR_SLICE_PIPE_CONFLICT_EN
    logic conflict;

    // a stage's own address colliding with bits pushed down from above
    always_comb begin
        conflict = 1'b0;
        for (int k = 1; k < S; k++) begin
            if (|(ia[k] & back[k+1])) conflict = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (in_valid && in_ready && conflict) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_permutator_slice_pipe.sv
// tb_permutator_slice_pipe: table vectors, directed handshake/config/reset
// sequences and a random phase, all checked through a scoreboard queue.
module tb_permutator_slice_pipe;

    localparam int S  = 4;
    localparam int DW = 32;
    localparam int TW = (S+1)*DW;
    localparam int AW = S*S;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] t_dat;
    logic [AW-1:0] i_adr;
    logic          cfg_wr;
    logic [S-1:0]  cfg_wdata;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] i_dat;
    logic [AW-1:0] t_adr;
    logic [S-1:0]  cfg_q;
`ifdef PERMUTATOR_SLICE_PIPE_CONFLICT_EN
    logic          err_clr;
    logic          err;
`endif

    permutator_slice_pipe #(
        .DW(DW),
        .STAGES(S),
        .CFG_RST('0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .t_dat    (t_dat),
        .i_adr    (i_adr),
        .cfg_wr   (cfg_wr),
        .cfg_wdata(cfg_wdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .i_dat    (i_dat),
        .t_adr    (t_adr),
        .cfg_q    (cfg_q)
`ifdef PERMUTATOR_SLICE_PIPE_CONFLICT_EN
        ,
        .err_clr  (err_clr),
        .err      (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0] d;
        logic [AW-1:0] a;
    } sb_t;

    typedef struct {
        logic [S-1:0]       cfg;
        logic [AW-1:0]      adr;
        logic [8*(S+1)-1:0] eb;
        logic [AW-1:0]      ea;
    } vec_t;

    int            n_chk  = 0;
    int            n_fail = 0;
    sb_t           sb[$];
    logic [TW-1:0] exp_d;
    logic [AW-1:0] exp_a;
    logic [S-1:0]  cfg_m = '0;
    logic [S-1:0]  cfg_cur = '0;
    bit            use_model = 1'b0;
    vec_t          vecs[5];

    task automatic check(input string nm, input logic [191:0] act,
                         input logic [191:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    function automatic sb_t model(input logic [TW-1:0] td,
                                  input logic [AW-1:0] ia,
                                  input logic [S-1:0] c);
        sb_t          r;
        logic [S-1:0] carry;
        logic [S-1:0] a;
        logic [S-1:0] rs;
        logic [S:0]   sv;
        r     = '0;
        carry = '0;
        sv    = '0;
        for (int k = S; k >= 1; k--) begin
            a  = carry;
            rs = '0;
            for (int b = 0; b < k; b++) a[b] = a[b] | ia[(k-1)*S + b];
            sv[k] = a[0] ^ c[S-k];
            for (int b = 1; b < k; b++) rs[b-1] = a[b];
            carry = sv[k] ? '0 : rs;
            if (sv[k]) r.a[(k-1)*S +: S] = rs;
        end
        r.d[DW-1:0] = td[DW-1:0];
        for (int k = 1; k <= S; k++) begin
            r.d[k*DW +: DW] = sv[k] ? td[k*DW +: DW] : r.d[(k-1)*DW +: DW];
        end
        return r;
    endfunction

    function automatic logic [TW-1:0] td_d();
        logic [TW-1:0] v;
        for (int k = 0; k <= S; k++) v[k*DW +: DW] = 32'hD0 + 32'(k);
        return v;
    endfunction

    function automatic logic [TW-1:0] expand(input logic [8*(S+1)-1:0] eb);
        logic [TW-1:0] v;
        v = '0;
        for (int k = 0; k <= S; k++) v[k*DW +: DW] = {24'h0, eb[k*8 +: 8]};
        return v;
    endfunction

    // scoreboard: pop what leaves, push what enters at the coming edge
    always @(negedge clk) begin
        sb_t b;
        if (rst) begin
            sb.delete();
            cfg_m = '0;
        end else begin
            check("cfg_q", cfg_q, cfg_m);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h expected none",
                             i_dat);
                end else begin
                    b = sb.pop_front();
                    check("i_dat", i_dat, b.d);
                    check("t_adr", t_adr, b.a);
                end
            end
            if (in_valid && in_ready) begin
                if (use_model) b = model(t_dat, i_adr, cfg_m);
                else           b = '{d: exp_d, a: exp_a};
                sb.push_back(b);
            end
            if (cfg_wr) cfg_m = cfg_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int limit);
        int n;
        bit acc;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < limit);
        if (!acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready 0 required 1");
        end
    endtask

    task automatic drive(input logic [TW-1:0] td, input logic [AW-1:0] a,
                         input logic [TW-1:0] ed, input logic [AW-1:0] ea);
        in_valid = 1'b1;
        t_dat    = td;
        i_adr    = a;
        exp_d    = ed;
        exp_a    = ea;
    endtask

    task automatic send(input logic [TW-1:0] td, input logic [AW-1:0] a,
                        input logic [TW-1:0] ed, input logic [AW-1:0] ea);
        drive(td, a, ed, ea);
        wait_acc(20);
        in_valid = 1'b0;
    endtask

    task automatic write_cfg(input logic [S-1:0] c);
        cfg_wr    = 1'b1;
        cfg_wdata = c;
        tick();
        cfg_wr  = 1'b0;
        cfg_cur = c;
    endtask

    function automatic logic [TW-1:0] tda(input logic [DW-1:0] x);
        return {{S{32'hEEEE0000}}, x};
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        t_dat     = '0;
        i_adr     = '0;
        cfg_wr    = 1'b0;
        cfg_wdata = '0;
        out_ready = 1'b1;
        exp_d     = '0;
        exp_a     = '0;
`ifdef PERMUTATOR_SLICE_PIPE_CONFLICT_EN
        err_clr   = 1'b0;
`endif

        vecs[0] = '{4'h0, 16'h1000, 40'hD4_D0_D0_D0_D0, 16'h0000};
        vecs[1] = '{4'h0, 16'hE000, 40'hD3_D3_D0_D0_D0, 16'h0300};
        vecs[2] = '{4'h0, 16'h0010, 40'hD2_D2_D2_D0_D0, 16'h0000};
        vecs[3] = '{4'hF, 16'h0000, 40'hD4_D3_D2_D1_D0, 16'h0000};
        vecs[4] = '{4'hF, 16'h1000, 40'hD3_D3_D2_D1_D0, 16'h0000};

        tick();
        tick();
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready_after", in_ready, 1'b1);
        check("rst_cfg_q", cfg_q, 4'h0);
        check("rst_i_dat", i_dat, '0);
        check("rst_t_adr", t_adr, '0);
`ifdef PERMUTATOR_SLICE_PIPE_CONFLICT_EN
        check("rst_err", err, 1'b0);
`endif
        tick();

        // table vectors
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].cfg != cfg_cur) write_cfg(vecs[i].cfg);
            send(td_d(), vecs[i].adr, expand(vecs[i].eb), vecs[i].ea);
            if (i == 0) begin
                @(negedge clk);
                check("latency_out_valid", out_valid, 1'b1);
                tick();
            end
        end
        repeat (3) tick();
        check("table_drain", sb.size(), 0);

        // skid fill and in-order drain
        write_cfg(4'h0);
        out_ready = 1'b0;
        send(tda(32'hA1), '0, {(S+1){32'hA1}}, '0);
        send(tda(32'hA2), '0, {(S+1){32'hA2}}, '0);
        drive(tda(32'hA3), '0, {(S+1){32'hA3}}, '0);
        repeat (3) begin
            @(negedge clk);
            check("full_in_ready", in_ready, 1'b0);
            check("full_hold", i_dat, {(S+1){32'hA1}});
            tick();
        end
        out_ready = 1'b1;
        wait_acc(5);
        in_valid = 1'b0;
        repeat (4) tick();
        check("skid_drain", sb.size(), 0);

        // config write coinciding with a beat
        cfg_wr    = 1'b1;
        cfg_wdata = 4'h1;
        drive(td_d(), 16'h1000, expand(40'hD4_D0_D0_D0_D0), '0);
        @(negedge clk);
        check("same_cycle_ready", in_ready, 1'b1);
        tick();
        cfg_wr   = 1'b0;
        in_valid = 1'b0;
        cfg_cur  = 4'h1;
        @(negedge clk);
        check("cfg_written", cfg_q, 4'h1);
        tick();
        send(td_d(), 16'h1000, expand(40'hD0_D0_D0_D0_D0), '0);
        repeat (3) tick();
        check("cfg_drain", sb.size(), 0);

        // reset with two beats buffered
        out_ready = 1'b0;
        send(tda(32'hB1), '0, '0, '0);
        send(tda(32'hB2), '0, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1'b0);
        tick();
        rst     = 1'b0;
        cfg_cur = 4'h0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_cfg_q", cfg_q, 4'h0);
        check("midrst_in_ready_after", in_ready, 1'b1);
        check("midrst_i_dat", i_dat, '0);
        tick();
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_stale", out_valid, 1'b0);
            tick();
        end

`ifdef PERMUTATOR_SLICE_PIPE_CONFLICT_EN
        send(td_d(), 16'h4200, expand(40'hD2_D2_D2_D0_D0), '0);
        repeat (2) begin
            @(negedge clk);
            check("err_set", err, 1'b1);
            tick();
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        check("err_clr", err, 1'b0);
        tick();
        send(td_d(), 16'h1000, expand(40'hD4_D0_D0_D0_D0), '0);
        @(negedge clk);
        check("err_no_conflict", err, 1'b0);
        tick();
`endif

        // random traffic against the reference model
        use_model = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            for (int k = 0; k <= S; k++) t_dat[k*DW +: DW] = $urandom;
            i_adr     = 16'($urandom);
            cfg_wr    = ($urandom_range(0, 7) == 0);
            cfg_wdata = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        cfg_wr    = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        check("final_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
